// File: rtl/sram_dp_port_arbiter.sv
// sram_dp_port_arbiter: round-robin grant of NREQ requesters onto the two ports of one SRAM, with a same-address collision guard.
// Latency: grant and SRAM drive are combinational; read data returns 1 cycle after the handshake, tagged to its requester.
// Backpressure: req_ready is withheld from requesters that are not granted; responses cannot be stalled.
// Optional build macro ARB_STATS_EN adds the stat_xfers / stat_conflicts counters.
module sram_dp_port_arbiter #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 13,
  parameter int NREQ       = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*2-1:0]          req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*BITS-1:0]       req_wdata,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [NREQ*BITS-1:0]       rsp_data,
  output logic                       CENA,
  output logic                       CENB,
  output logic [1:0]                 WENA,
  output logic [1:0]                 WENB,
  output logic [ADDR_WIDTH-1:0]      AA,
  output logic [ADDR_WIDTH-1:0]      AB,
  output logic [BITS-1:0]            DA,
  output logic [BITS-1:0]            DB,
  input  logic [BITS-1:0]            QA,
  input  logic [BITS-1:0]            QB
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                stat_xfers,
  output logic [15:0]                stat_conflicts
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] idx_t;

  // Next requester index in the circular scan.
  function automatic idx_t inc_mod(input idx_t v);
    if (int'(v) == NREQ - 1) return '0;
    else return v + idx_t'(1);
  endfunction

  logic [1:0]            we_i    [NREQ];
  logic [ADDR_WIDTH-1:0] addr_i  [NREQ];
  logic [BITS-1:0]       wdata_i [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign we_i[g]    = req_we[g*2 +: 2];
    assign addr_i[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_i[g] = req_wdata[g*BITS +: BITS];
  end

  idx_t            rr_ptr;
  idx_t            a_idx, b_idx, scan_idx;
  logic            a_vld, b_vld, b_gnt, conflict;
  logic            rd_a, rd_b;
  logic [NREQ-1:0] rd_pend, rd_tag;
  logic [NREQ-1:0] pend_nxt, tag_nxt;

  // Circular scan from rr_ptr: first valid requester takes port A, second takes port B.
  // Nothing is granted while reset is held so the SRAM stays deselected.
  always_comb begin
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[scan_idx] && !RST) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = scan_idx;
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = scan_idx;
        end
      end
      scan_idx = inc_mod(scan_idx);
    end
  end

  // Same word on both ports is only safe when both are reads; otherwise B backs off and retries.
  assign conflict = a_vld && b_vld && (addr_i[a_idx] == addr_i[b_idx]) &&
                    ((we_i[a_idx] != 2'b00) || (we_i[b_idx] != 2'b00));
  assign b_gnt    = b_vld && !conflict;
  assign rd_a     = a_vld && (we_i[a_idx] == 2'b00);
  assign rd_b     = b_gnt && (we_i[b_idx] == 2'b00);

  // Ready goes only to the requesters that actually own a port this cycle.
  always_comb begin
    req_ready = '0;
    if (a_vld) req_ready[a_idx] = 1'b1;
    if (b_gnt) req_ready[b_idx] = 1'b1;
  end

  assign CENA = !a_vld;
  assign WENA = a_vld ? ~we_i[a_idx]    : 2'b11;
  assign AA   = a_vld ? addr_i[a_idx]  : '0;
  assign DA   = a_vld ? wdata_i[a_idx] : '0;
  assign CENB = !b_gnt;
  assign WENB = b_gnt ? ~we_i[b_idx]    : 2'b11;
  assign AB   = b_gnt ? addr_i[b_idx]  : '0;
  assign DB   = b_gnt ? wdata_i[b_idx] : '0;

  // Per-requester read-pending flag and port tag for the response one cycle later.
  always_comb begin
    pend_nxt = '0;
    tag_nxt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_nxt[i] = (rd_a && (a_idx == idx_t'(i))) || (rd_b && (b_idx == idx_t'(i)));
      tag_nxt[i]  = rd_b && (b_idx == idx_t'(i));
    end
  end

  // Pointer follows the last granted port, so a withdrawn B heads the next scan.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr  <= '0;
      rd_pend <= '0;
      rd_tag  <= '0;
    end else begin
      rd_pend <= pend_nxt;
      rd_tag  <= tag_nxt;
      if (b_gnt)      rr_ptr <= inc_mod(b_idx);
      else if (a_vld) rr_ptr <= inc_mod(a_idx);
    end
  end

  assign rsp_valid = rd_pend;

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign rsp_data[g*BITS +: BITS] = !rd_pend[g] ? '0 : (rd_tag[g] ? QB : QA);
  end

`ifdef ARB_STATS_EN
  // Handshake count wraps; conflict count sticks at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_xfers     <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_xfers <= stat_xfers + {31'b0, a_vld} + {31'b0, b_gnt};
      if (conflict && (stat_conflicts != 16'hFFFF))
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_dp_port_arbiter.sv
module tb_sram_dp_port_arbiter;

  localparam int BITS = 64;
  localparam int AW   = 13;
  localparam int N    = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*2-1:0]  req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*BITS-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [N*BITS-1:0] rsp_data;
  logic            CENA, CENB;
  logic [1:0]      WENA, WENB;
  logic [AW-1:0]   AA, AB;
  logic [BITS-1:0] DA, DB, QA, QB;
`ifdef ARB_STATS_EN
  logic [31:0]     stat_xfers;
  logic [15:0]     stat_conflicts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sram_dp_port_arbiter #(.BITS(BITS), .ADDR_WIDTH(AW), .NREQ(N)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
    .AA(AA), .AB(AB), .DA(DA), .DB(DB), .QA(QA), .QB(QB)
`ifdef ARB_STATS_EN
    , .stat_xfers(stat_xfers), .stat_conflicts(stat_conflicts)
`endif
  );

  // Dual-port SRAM: registered read, active-low enables, half-word write mask.
  bit [63:0] mem [8192];
  always @(posedge CLK) begin
    if (!CENA) begin
      if (WENA == 2'b11) QA <= mem[AA];
      else begin
        if (!WENA[1]) mem[AA][63:32] <= DA[63:32];
        if (!WENA[0]) mem[AA][31:0]  <= DA[31:0];
      end
    end
    if (!CENB) begin
      if (WENB == 2'b11) QB <= mem[AB];
      else begin
        if (!WENB[1]) mem[AB][63:32] <= DB[63:32];
        if (!WENB[0]) mem[AB][31:0]  <= DB[31:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: word memory, round-robin pointer, pending responses, stats.
  bit [63:0]  ref_mem [8192];
  int         m_ptr = 0;
  bit [N-1:0] m_pend = '0;
  bit [63:0]  m_data [N];
  int         m_xfers = 0;
  int         m_conf = 0;

  always @(negedge CLK) begin
    int order[$];
    int a, b;
    bit ga, gb, cf;
    logic [N-1:0] e_rdy;
    order.delete();
    ga = 0; gb = 0; cf = 0; a = 0; b = 0; e_rdy = '0;
    if (!RST) begin
      for (int k = 0; k < N; k++)
        if (req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      if (order.size() >= 1) begin ga = 1; a = order[0]; end
      if (order.size() >= 2) begin gb = 1; b = order[1]; end
      if (gb && req_addr[a*AW +: AW] == req_addr[b*AW +: AW] &&
          (req_we[a*2 +: 2] != 2'b00 || req_we[b*2 +: 2] != 2'b00)) begin
        gb = 0; cf = 1;
      end
      if (ga) e_rdy[a] = 1'b1;
      if (gb) e_rdy[b] = 1'b1;
    end
    chk("m_ready", req_ready, e_rdy);
    chk("m_port_a", {CENA, WENA, AA, DA},
        {!ga, ga ? ~req_we[a*2 +: 2] : 2'b11, ga ? req_addr[a*AW +: AW] : 13'h0,
         ga ? req_wdata[a*BITS +: BITS] : 64'h0});
    chk("m_port_b", {CENB, WENB, AB, DB},
        {!gb, gb ? ~req_we[b*2 +: 2] : 2'b11, gb ? req_addr[b*AW +: AW] : 13'h0,
         gb ? req_wdata[b*BITS +: BITS] : 64'h0});
    chk("m_rsp_valid", rsp_valid, RST ? '0 : m_pend);
    for (int i = 0; i < N; i++)
      if (m_pend[i] && !RST) chk("m_rsp_data", rsp_data[i*BITS +: BITS], m_data[i]);

    if (RST) begin
      m_ptr = 0; m_pend = '0; m_xfers = 0; m_conf = 0;
    end else begin
      m_pend = '0;
      if (ga && req_we[a*2 +: 2] == 2'b00) begin
        m_pend[a] = 1; m_data[a] = ref_mem[req_addr[a*AW +: AW]];
      end
      if (gb && req_we[b*2 +: 2] == 2'b00) begin
        m_pend[b] = 1; m_data[b] = ref_mem[req_addr[b*AW +: AW]];
      end
      for (int p = 0; p < 2; p++) begin
        int r;
        r = (p == 0) ? a : b;
        if ((p == 0 && ga) || (p == 1 && gb)) begin
          if (req_we[r*2 + 1]) ref_mem[req_addr[r*AW +: AW]][63:32] = req_wdata[r*BITS + 32 +: 32];
          if (req_we[r*2])     ref_mem[req_addr[r*AW +: AW]][31:0]  = req_wdata[r*BITS +: 32];
        end
      end
      m_xfers = m_xfers + int'(ga) + int'(gb);
      if (cf && m_conf != 65535) m_conf++;
      if (gb) m_ptr = (b + 1) % N;
      else if (ga) m_ptr = (a + 1) % N;
    end
  end

  task automatic put(input int i, input logic [1:0] we, input logic [AW-1:0] ad, input logic [63:0] d);
    req_we[i*2 +: 2]        = we;
    req_addr[i*AW +: AW]    = ad;
    req_wdata[i*BITS +: BITS] = d;
    req_valid[i]            = 1'b1;
  endtask

  // Hold requests until each is handshaken, bounded by a cycle budget.
  task automatic drain(input int bound);
    int n;
    logic [N-1:0] g;
    n = 0;
    while (req_valid != '0 && n < bound) begin
      @(negedge CLK);
      g = req_valid & req_ready;
      @(posedge CLK); #1;
      req_valid = req_valid & ~g;
      n++;
    end
    chk("drain_done", req_valid, '0);
  endtask

  logic [N-1:0] fair_tab [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fair_tab = '{3'b011, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110};
    RST = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rsp_valid", rsp_valid, 3'b000);
    chk("rst_cen", {CENA, CENB}, 2'b11);
    chk("rst_wen", {WENA, WENB}, 4'b1111);
    @(posedge CLK); #1 RST = 1'b0;

    // Load the two words used by the dual read.
    put(0, 2'b11, 13'h010, 64'hA5A5_A5A5_A5A5_A5A5);
    put(1, 2'b11, 13'h020, 64'h5A5A_5A5A_5A5A_5A5A);
    @(negedge CLK); chk("first_grant", req_ready, 3'b011);
    @(posedge CLK); #1 req_valid = '0;

    // Dual read, both ports in one cycle.
    put(0, 2'b00, 13'h010, 64'h0);
    put(1, 2'b00, 13'h020, 64'h0);
    @(negedge CLK); chk("dual_rdy", req_ready, 3'b011);
    @(posedge CLK); #1 req_valid = '0;
    @(negedge CLK);
    chk("dual_rsp_vld", rsp_valid, 3'b011);
    chk("dual_rsp0", rsp_data[0 +: 64], 64'hA5A5_A5A5_A5A5_A5A5);
    chk("dual_rsp1", rsp_data[64 +: 64], 64'h5A5A_5A5A_5A5A_5A5A);

    // Write/read collision on 0x040: reader retries and sees new data.
    @(posedge CLK); #1;
    put(0, 2'b11, 13'h040, 64'hDEAD_BEEF_0123_4567);
    put(1, 2'b00, 13'h040, 64'h0);
    @(negedge CLK); chk("conf_rdy1", req_ready, 3'b001);
    @(posedge CLK); #1 req_valid[0] = 1'b0;
    @(negedge CLK); chk("conf_rdy2", req_ready, 3'b010);
    @(posedge CLK); #1 req_valid = '0;
    @(negedge CLK);
    chk("conf_rsp_vld", rsp_valid, 3'b010);
    chk("conf_rsp1", rsp_data[64 +: 64], 64'hDEAD_BEEF_0123_4567);

    // Half-word write merge.
    @(posedge CLK); #1 put(2, 2'b11, 13'h007, 64'h1111_2222_3333_4444);
    @(negedge CLK); chk("hw_rdy1", req_ready, 3'b100);
    @(posedge CLK); #1 put(2, 2'b10, 13'h007, 64'hFFFF_FFFF_0000_0000);
    @(negedge CLK); chk("hw_rdy2", req_ready, 3'b100);
    @(posedge CLK); #1 put(2, 2'b00, 13'h007, 64'h0);
    @(negedge CLK); chk("hw_rdy3", req_ready, 3'b100);
    @(posedge CLK); #1 req_valid = '0;
    @(negedge CLK);
    chk("hw_rsp_vld", rsp_valid, 3'b100);
    chk("hw_rsp2", rsp_data[128 +: 64], 64'hFFFF_FFFF_3333_4444);

    // Fairness: all three continuously valid, pointer at 0.
    @(posedge CLK); #1;
    put(0, 2'b00, 13'h010, 64'h0);
    put(1, 2'b00, 13'h020, 64'h0);
    put(2, 2'b00, 13'h007, 64'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK); chk("fair", req_ready, fair_tab[c]);
      @(posedge CLK); #1;
    end
    req_valid = '0;

    // Write/write collision, a shared read, and a read/write collision.
    put(0, 2'b01, 13'h050, 64'h0000_0000_AAAA_BBBB);
    put(1, 2'b10, 13'h050, 64'hCCCC_DDDD_0000_0000);
    put(2, 2'b00, 13'h060, 64'h0);
    @(negedge CLK); chk("ww_rdy", req_ready, 3'b001);
    @(posedge CLK); #1 req_valid[0] = 1'b0;
    drain(10);
    put(0, 2'b00, 13'h050, 64'h0);
    put(2, 2'b00, 13'h050, 64'h0);
    @(negedge CLK); chk("rr_rdy", req_ready, 3'b101);
    @(posedge CLK); #1 req_valid = '0;
    @(negedge CLK);
    chk("rr_rsp0", rsp_data[0 +: 64], 64'hCCCC_DDDD_AAAA_BBBB);
    chk("rr_rsp2", rsp_data[128 +: 64], 64'hCCCC_DDDD_AAAA_BBBB);
    @(posedge CLK); #1;
    put(1, 2'b00, 13'h060, 64'h0);
    put(2, 2'b11, 13'h060, 64'h7777_8888_9999_AAAA);
    @(negedge CLK); chk("rw_rdy", req_ready, 3'b010);
    @(posedge CLK); #1 req_valid[1] = 1'b0;
    drain(10);
`ifdef ARB_STATS_EN
    chk("stat_xfers", stat_xfers, m_xfers);
    chk("stat_conflicts", stat_conflicts, 16'd3);
`endif

    // Reset in the middle of traffic drops the in-flight response.
    put(0, 2'b00, 13'h010, 64'h0);
    put(1, 2'b00, 13'h020, 64'h0);
    put(2, 2'b00, 13'h040, 64'h0);
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("mrst_rsp_vld", rsp_valid, 3'b000);
    chk("mrst_sram", {CENA, CENB, WENA, WENB}, 6'b111111);
    chk("mrst_rdy", req_ready, 3'b000);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK); chk("mrst_first_grant", req_ready, 3'b011);
    @(posedge CLK); #1 req_valid = req_valid & ~3'b011;
    drain(10);
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
